avalon_multi_timer: RTL

- Parametrised successor to the single 16-bit-bus Avalon interval timer.
- Holds N_CH independent down-counting timers of COUNT_W bits. Each channel has its own prescaler, period, one-shot/continuous mode, snapshot and interrupt.
- Sits on a 32-bit Avalon-MM slave port beside the Nios cores.
- Drives one irq per channel plus a combined irq line.

---
 rtl/avalon_multi_timer_pkg.sv | 52 +++++
 rtl/avalon_multi_timer_if.sv | 28 ++
 rtl/avalon_timer_channel.sv | 111 +++++++++++
 rtl/avalon_multi_timer.sv | 105 ++++++++++
 4 files changed

// File: rtl/avalon_multi_timer_pkg.sv
// -----------------------------------------------------------------------------
// avalon_multi_timer_pkg
// Shared definitions for the multi-channel Avalon interval timer:
//   - per-channel register offsets
//   - CONTROL / STATUS bit positions
//   - per-channel write-strobe bundle
//   - address-width helpers used by the top level and its instantiators
// -----------------------------------------------------------------------------
package avalon_multi_timer_pkg;

    typedef enum logic [2:0] {
        OFS_STATUS   = 3'd0,
        OFS_CONTROL  = 3'd1,
        OFS_PERIOD   = 3'd2,
        OFS_SNAP     = 3'd3,
        OFS_PRESCALE = 3'd4,
        OFS_COUNT    = 3'd5,
        OFS_RSVD6    = 3'd6,
        OFS_RSVD7    = 3'd7
    } reg_ofs_e;

    // CONTROL bits (START/STOP are write-only strobes)
    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // STATUS bits
    localparam int STS_TO  = 0;
    localparam int STS_RUN = 1;

    // Decoded write strobes for one channel
    typedef struct packed {
        logic status;
        logic control;
        logic period;
        logic snap;
        logic prescale;
    } ch_wr_t;

    // The channel field is wide enough to express index N_CH itself, so
    // accesses one past the last channel decode as "no channel" rather than
    // aliasing onto a real one.
    function automatic int ch_sel_w(input int n_ch);
        return $clog2(n_ch + 1);
    endfunction

    function automatic int addr_w(input int n_ch);
        return ch_sel_w(n_ch) + 3;
    endfunction

endpackage

// File: rtl/avalon_multi_timer_if.sv
// -----------------------------------------------------------------------------
// avalon_multi_timer_if
// Avalon-MM slave bus bundle for avalon_multi_timer.
//   address    word address: [AW-1:3] channel, [2:0] register offset
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
interface avalon_multi_timer_if #(
    parameter int AW = 6
);
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_timer_channel.sv
// -----------------------------------------------------------------------------
// avalon_timer_channel
// One down-counting timer channel with prescaler, one-shot/continuous mode,
// snapshot register and interrupt.
//   clk, reset_n  clock, asynchronous active-low reset
//   wr            decoded write strobes for this channel's registers
//   wdata         bus write data
//   status        {RUN, TO}
//   control       {CONT, ITO}
//   period        reload value
//   snap          last captured counter value
//   prescale      prescaler terminal count
//   count         live counter
//   irq           TO & ITO
// -----------------------------------------------------------------------------
module avalon_timer_channel
    import avalon_multi_timer_pkg::*;
#(
    parameter int          COUNT_W        = 32,
    parameter int          PRESC_W        = 16,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999
) (
    input  logic               clk,
    input  logic               reset_n,
    input  ch_wr_t             wr,
    input  logic [31:0]        wdata,
    output logic [1:0]         status,
    output logic [1:0]         control,
    output logic [COUNT_W-1:0] period,
    output logic [COUNT_W-1:0] snap,
    output logic [PRESC_W-1:0] prescale,
    output logic [COUNT_W-1:0] count,
    output logic               irq
);

    logic               run;
    logic               to;
    logic               ito;
    logic               cont;
    logic               force_reload;  // PERIOD was written on the previous edge
    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               timeout;

    always_comb begin
        tick    = run && (presc_cnt == prescale);
        timeout = tick && (count == '0);
    end

    // NOTE: every register here is a small flop with a defined reset value, so
    // all of them clear asynchronously; nothing is a RAM that would need to be
    // left out of the reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period       <= DEFAULT_PERIOD[COUNT_W-1:0];
            count        <= DEFAULT_PERIOD[COUNT_W-1:0];
            snap         <= '0;
            prescale     <= '0;
            presc_cnt    <= '0;
            ito          <= 1'b0;
            cont         <= 1'b0;
            run          <= 1'b0;
            to           <= 1'b0;
            force_reload <= 1'b0;
        end else begin
            force_reload <= wr.period;
            if (wr.period)   period   <= wdata[COUNT_W-1:0];
            if (wr.prescale) prescale <= wdata[PRESC_W-1:0];
            if (wr.snap)     snap     <= count;   // value before this edge's decrement
            if (wr.control) begin
                ito  <= wdata[CTL_ITO];
                cont <= wdata[CTL_CONT];
            end

            // A prescale lowered below the running count lets the count run
            // on to all-ones and wrap naturally.
            if (run)          presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick)         count     <= (count == '0) ? period : count - 1'b1;
            if (timeout && !cont) run   <= 1'b0;

            // NOTE: non-blocking assignments below override the ones above
            // within the same edge, which is how priority is expressed:
            // force reload beats counting, STOP beats run, START beats STOP.
            if (force_reload) begin
                count     <= period;
                presc_cnt <= '0;
                run       <= 1'b0;
            end
            if (wr.control && wdata[CTL_STOP]) run <= 1'b0;
            if (wr.control && wdata[CTL_START]) begin
                run       <= 1'b1;
                presc_cnt <= '0;
            end

            // A timeout in the same cycle as a STATUS write must not be lost.
            if (timeout)        to <= 1'b1;
            else if (wr.status) to <= 1'b0;
        end
    end

    always_comb begin
        status           = '0;
        status[STS_TO]   = to;
        status[STS_RUN]  = run;
        control          = '0;
        control[CTL_ITO] = ito;
        control[CTL_CONT]= cont;
        irq              = to && ito;
    end

endmodule

// File: rtl/avalon_multi_timer.sv
// -----------------------------------------------------------------------------
// avalon_multi_timer
// N_CH independent interval timers on a 32-bit Avalon-MM slave port.
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           Avalon-MM slave (address, chipselect, write_n, writedata,
//                 readdata); readdata is registered, 1-cycle latency
//   irq_ch        per-channel interrupt
//   irq           OR of irq_ch
// The top level only decodes addresses, muxes reads and registers readdata.
// -----------------------------------------------------------------------------
module avalon_multi_timer
    import avalon_multi_timer_pkg::*;
#(
    parameter int          N_CH           = 4,
    parameter int          COUNT_W        = 32,
    parameter int          PRESC_W        = 16,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avalon_multi_timer_if.slave   bus,
    output logic [N_CH-1:0]       irq_ch,
    output logic                  irq
);

    localparam int CH_W = ch_sel_w(N_CH);

    logic [CH_W-1:0]    ch_idx;
    reg_ofs_e           ofs;
    logic               wr_en;
    logic [31:0]        rd_mux;

    logic [1:0]         status   [N_CH];
    logic [1:0]         control  [N_CH];
    logic [COUNT_W-1:0] period   [N_CH];
    logic [COUNT_W-1:0] snap     [N_CH];
    logic [PRESC_W-1:0] prescale [N_CH];
    logic [COUNT_W-1:0] count    [N_CH];

    assign ch_idx = bus.address[CH_W+2:3];
    assign ofs    = reg_ofs_e'(bus.address[2:0]);
    assign wr_en  = bus.chipselect && !bus.write_n;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic   sel;
        ch_wr_t wr;

        always_comb begin
            sel         = wr_en && (ch_idx == CH_W'(i));
            wr          = '0;
            wr.status   = sel && (ofs == OFS_STATUS);
            wr.control  = sel && (ofs == OFS_CONTROL);
            wr.period   = sel && (ofs == OFS_PERIOD);
            wr.snap     = sel && (ofs == OFS_SNAP);
            wr.prescale = sel && (ofs == OFS_PRESCALE);
        end

        avalon_timer_channel #(
            .COUNT_W        (COUNT_W),
            .PRESC_W        (PRESC_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr       (wr),
            .wdata    (bus.writedata),
            .status   (status[i]),
            .control  (control[i]),
            .period   (period[i]),
            .snap     (snap[i]),
            .prescale (prescale[i]),
            .count    (count[i]),
            .irq      (irq_ch[i])
        );
    end

    // Channel indices >= N_CH match no loop iteration and read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_idx == CH_W'(i)) begin
                case (ofs)
                    OFS_STATUS:   rd_mux = 32'(status[i]);
                    OFS_CONTROL:  rd_mux = 32'(control[i]);
                    OFS_PERIOD:   rd_mux = 32'(period[i]);
                    OFS_SNAP:     rd_mux = 32'(snap[i]);
                    OFS_PRESCALE: rd_mux = 32'(prescale[i]);
                    OFS_COUNT:    rd_mux = 32'(count[i]);
                    default:      rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= bus.chipselect ? rd_mux : '0;
        end
    end

    assign irq = |irq_ch;

endmodule
